// File: rtl/prpg_checker_if.sv
// ---------------------------------------------------------------------------
// prpg_checker_if
//   Bundles the configuration, pattern-stream and statistics signals of the
//   PRPG checker so a test controller and the checker connect through a
//   single port.
//
//   master modport (test controller):
//     drives  cfg_valid, cfg_tap[6:0], start, in_valid, in_pat[0:7]
//     reads   locked, err_flag, sync_loss, hd_last[3:0],
//             word_cnt, err_cnt, bit_err_cnt (CNT_W bits each)
//   slave modport (checker): the mirror image.
// ---------------------------------------------------------------------------
interface prpg_checker_if #(
   parameter int CNT_W = 16
);
   logic             cfg_valid;
   logic [6:0]       cfg_tap;
   logic             start;
   logic             in_valid;
   logic [0:7]       in_pat;

   logic             locked;
   logic             err_flag;
   logic             sync_loss;
   logic [3:0]       hd_last;
   logic [CNT_W-1:0] word_cnt;
   logic [CNT_W-1:0] err_cnt;
   logic [CNT_W-1:0] bit_err_cnt;

   modport master (
      output cfg_valid, cfg_tap, start, in_valid, in_pat,
      input  locked, err_flag, sync_loss, hd_last, word_cnt, err_cnt, bit_err_cnt
   );

   modport slave (
      input  cfg_valid, cfg_tap, start, in_valid, in_pat,
      output locked, err_flag, sync_loss, hd_last, word_cnt, err_cnt, bit_err_cnt
   );
endinterface

// File: rtl/prpg_checker.sv
// ---------------------------------------------------------------------------
// prpg_checker
//   Receive-side checker for the LFSR pattern generator. It seeds its
//   predictor from the incoming stream, acquires lock after LOCK_CNT
//   consecutive correct predictions, then flywheels the predictor and counts
//   mismatching words and bit errors. LOSS_THR consecutive misses while
//   locked force resynchronisation.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    prpg_checker_if.slave: config, stream input, status/statistics
//
//   Parameters:
//     LOCK_CNT  consecutive matches needed to lock      (1..15)
//     LOSS_THR  consecutive misses that drop lock       (1..15)
//     CNT_W     statistics counter width (>= 4, must match the interface)
//
//   Bit order: in_pat and the predictor are [0:7]; index 0 is the leftmost
//   (most significant) bit of the word as written in hex.
// ---------------------------------------------------------------------------
module prpg_checker #(
   parameter int LOCK_CNT = 4,
   parameter int LOSS_THR = 3,
   parameter int CNT_W    = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   prpg_checker_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEED    = 2'd1,
      ACQUIRE = 2'd2,
      LOCKED  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [6:0]       tap_q, tap_d;
   logic [0:7]       exp_q, exp_d;
   logic [3:0]       match_run_q, match_run_d;
   logic [3:0]       miss_run_q, miss_run_d;
   logic [3:0]       hd_q, hd_d;
   logic             err_flag_q, err_flag_d;
   logic             sync_loss_q, sync_loss_d;
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0] bit_err_cnt_q, bit_err_cnt_d;

   logic [3:0]       hd_now;
   logic             word_match;
   logic             lock_hit;
   logic             loss_hit;

   // One generator step: rotate toward higher index, XOR the tapped stages
   // with the bit that wrapped around. Must stay bit-exact with the generator.
   function automatic logic [0:7] lfsr_step(input logic [0:7] c, input logic [6:0] tap);
      logic [0:7] n;
      n[0] = c[7];
      for (int k = 1; k < 8; k++) begin
         n[k] = c[k-1] ^ (tap[7-k] & c[7]);
      end
      return n;
   endfunction

   function automatic logic [3:0] popcount8(input logic [0:7] v);
      logic [3:0] s;
      s = '0;
      for (int i = 0; i < 8; i++) begin
         s = s + {3'b000, v[i]};
      end
      return s;
   endfunction

   // Add with clamp at all-ones; one extra bit catches the carry-out.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {{(CNT_W-3){1'b0}}, b};
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   assign hd_now     = popcount8(bus.in_pat ^ exp_q);
   assign word_match = (hd_now == 4'd0);
   // The run counters are compared as "this word would make it N".
   assign lock_hit   = (({1'b0, match_run_q} + 5'd1) == 5'(LOCK_CNT));
   assign loss_hit   = (({1'b0, miss_run_q}  + 5'd1) == 5'(LOSS_THR));

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state is written with <= so every register samples
      // the pre-edge values regardless of statement order.
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      // NOTE: a default ahead of the case means no branch can leave state_d
      // unassigned, so no latch is inferred.
      state_d = state_q;
      if (bus.start) begin
         state_d = SEED;
      end else begin
         unique case (state_q)
            IDLE:    state_d = IDLE;
            SEED:    if (bus.in_valid) state_d = ACQUIRE;
            ACQUIRE: if (bus.in_valid && word_match && lock_hit) state_d = LOCKED;
            LOCKED:  if (bus.in_valid && !word_match && loss_hit) state_d = ACQUIRE;
            default: state_d = IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- datapath / outputs
   always_comb begin
      tap_d         = tap_q;
      exp_d         = exp_q;
      match_run_d   = match_run_q;
      miss_run_d    = miss_run_q;
      hd_d          = hd_q;
      err_flag_d    = 1'b0;
      sync_loss_d   = 1'b0;
      word_cnt_d    = word_cnt_q;
      err_cnt_d     = err_cnt_q;
      bit_err_cnt_d = bit_err_cnt_q;

      if (bus.start) begin
         // start wins over any in_valid word; the tap survives a restart.
         if (state_q == IDLE && bus.cfg_valid) tap_d = bus.cfg_tap;
         match_run_d   = '0;
         miss_run_d    = '0;
         hd_d          = '0;
         word_cnt_d    = '0;
         err_cnt_d     = '0;
         bit_err_cnt_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.cfg_valid) tap_d = bus.cfg_tap;
            end
            SEED: begin
               if (bus.in_valid) begin
                  exp_d       = lfsr_step(bus.in_pat, tap_q);
                  match_run_d = '0;
               end
            end
            ACQUIRE: begin
               if (bus.in_valid) begin
                  hd_d  = hd_now;
                  // While acquiring, always predict from what was received.
                  exp_d = lfsr_step(bus.in_pat, tap_q);
                  if (!word_match || lock_hit) match_run_d = '0;
                  else                         match_run_d = match_run_q + 4'd1;
               end
            end
            LOCKED: begin
               if (bus.in_valid) begin
                  hd_d       = hd_now;
                  // Flywheel: a corrupted word must not pollute the predictor.
                  exp_d      = lfsr_step(exp_q, tap_q);
                  word_cnt_d = sat_add(word_cnt_q, 4'd1);
                  if (word_match) begin
                     miss_run_d = '0;
                  end else begin
                     err_cnt_d     = sat_add(err_cnt_q, 4'd1);
                     bit_err_cnt_d = sat_add(bit_err_cnt_q, hd_now);
                     err_flag_d    = 1'b1;
                     if (loss_hit) begin
                        sync_loss_d = 1'b1;
                        exp_d       = lfsr_step(bus.in_pat, tap_q);
                        match_run_d = '0;
                        miss_run_d  = '0;
                     end else begin
                        miss_run_d = miss_run_q + 4'd1;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tap_q         <= '0;
         exp_q         <= '0;
         match_run_q   <= '0;
         miss_run_q    <= '0;
         hd_q          <= '0;
         err_flag_q    <= 1'b0;
         sync_loss_q   <= 1'b0;
         word_cnt_q    <= '0;
         err_cnt_q     <= '0;
         bit_err_cnt_q <= '0;
      end else begin
         tap_q         <= tap_d;
         exp_q         <= exp_d;
         match_run_q   <= match_run_d;
         miss_run_q    <= miss_run_d;
         hd_q          <= hd_d;
         err_flag_q    <= err_flag_d;
         sync_loss_q   <= sync_loss_d;
         word_cnt_q    <= word_cnt_d;
         err_cnt_q     <= err_cnt_d;
         bit_err_cnt_q <= bit_err_cnt_d;
      end
   end

   assign bus.locked      = (state_q == LOCKED);
   assign bus.err_flag    = err_flag_q;
   assign bus.sync_loss   = sync_loss_q;
   assign bus.hd_last     = hd_q;
   assign bus.word_cnt    = word_cnt_q;
   assign bus.err_cnt     = err_cnt_q;
   assign bus.bit_err_cnt = bit_err_cnt_q;

endmodule

// File: tb/tb_prpg_checker.sv
// ---------------------------------------------------------------------------
// tb_prpg_checker
//   Directed bench for prpg_checker (LOCK_CNT=4, LOSS_THR=3, CNT_W=4).
//   Stream words for tap 7'b0100101 from seed 8'hFF:
//     FF DA 6D 93 EC 76 3B B8 5C 2E 17 AE 57 8E 47 86 43 84 42
// ---------------------------------------------------------------------------
module tb_prpg_checker;

   localparam logic [6:0] TAP = 7'b0100101;

   logic clk;
   logic rst_n;

   prpg_checker_if #(.CNT_W(4)) bus ();

   prpg_checker #(
      .LOCK_CNT (4),
      .LOSS_THR (3),
      .CNT_W    (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       st;
      logic       cv;
      logic [6:0] tap;
      logic       iv;
      logic [7:0] pat;
      logic       e_lock;
      logic       e_err;
      logic       e_loss;
      logic [3:0] e_hd;
      logic [3:0] e_word;
      logic [3:0] e_errc;
      logic [3:0] e_bit;
   } vec_t;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   // Generator reference written on a numeric [7:0] view: rotate right,
   // then XOR the tap mask in when the wrapped bit is 1.
   function automatic logic [7:0] tb_step(input logic [7:0] v, input logic [6:0] tap);
      return {v[0], v[7:1]} ^ (v[0] ? {1'b0, tap} : 8'h00);
   endfunction

   function automatic vec_t mk(input logic st, input logic cv, input logic [6:0] tap,
                               input logic iv, input logic [7:0] pat,
                               input logic lk, input logic ef, input logic sl,
                               input logic [3:0] hd, input logic [3:0] wc,
                               input logic [3:0] ec, input logic [3:0] bc);
      vec_t v;
      v.st = st; v.cv = cv; v.tap = tap; v.iv = iv; v.pat = pat;
      v.e_lock = lk; v.e_err = ef; v.e_loss = sl; v.e_hd = hd;
      v.e_word = wc; v.e_errc = ec; v.e_bit = bc;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic lk, input logic ef, input logic sl,
                             input logic [3:0] hd, input logic [3:0] wc,
                             input logic [3:0] ec, input logic [3:0] bc);
      check({tag, ".locked"},      32'(bus.locked),      32'(lk));
      check({tag, ".err_flag"},    32'(bus.err_flag),    32'(ef));
      check({tag, ".sync_loss"},   32'(bus.sync_loss),   32'(sl));
      check({tag, ".hd_last"},     32'(bus.hd_last),     32'(hd));
      check({tag, ".word_cnt"},    32'(bus.word_cnt),    32'(wc));
      check({tag, ".err_cnt"},     32'(bus.err_cnt),     32'(ec));
      check({tag, ".bit_err_cnt"}, 32'(bus.bit_err_cnt), 32'(bc));
   endtask

   // Present one cycle of inputs from the falling edge; outputs are then
   // observed 1 time unit after the rising edge that registers them.
   task automatic drive(input logic st, input logic cv, input logic [6:0] tap,
                        input logic iv, input logic [7:0] pat);
      @(negedge clk);
      bus.start     = st;
      bus.cfg_valid = cv;
      bus.cfg_tap   = tap;
      bus.in_valid  = iv;
      bus.in_pat    = pat;
      @(posedge clk);
      #1;
      bus.start     = 1'b0;
      bus.cfg_valid = 1'b0;
      bus.in_valid  = 1'b0;
   endtask

   task automatic send(input logic [7:0] pat);
      drive(1'b0, 1'b0, 7'h00, 1'b1, pat);
   endtask

   vec_t       tbl[$];
   logic [7:0] pw;

   initial begin
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.cfg_valid = 1'b0;
      bus.cfg_tap   = 7'h00;
      bus.in_valid  = 1'b0;
      bus.in_pat    = 8'h00;

      //            st cv tap   iv pat    lk ef sl hd wc ec bc
      // lock: cfg_valid together with start, then 4 seed/acquire words
      tbl.push_back(mk(1, 1, TAP,  0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 7'h0, 1, 8'hFF, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 7'h0, 1, 8'hDA, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 7'h0, 1, 8'h6D, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 7'h0, 1, 8'h93, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 7'h0, 1, 8'hEC, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 7'h0, 1, 8'h76, 1, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 7'h0, 1, 8'h3B, 1, 0, 0, 0, 2, 0, 0));
      tbl.push_back(mk(0, 0, 7'h0, 0, 8'h5A, 1, 0, 0, 0, 2, 0, 0));  // gap
      tbl.push_back(mk(0, 0, 7'h0, 1, 8'hB8, 1, 0, 0, 0, 3, 0, 0));
      // single error: 5C with bit 0 flipped, then flywheel still matches
      tbl.push_back(mk(0, 0, 7'h0, 1, 8'hDC, 1, 1, 0, 1, 4, 1, 1));
      tbl.push_back(mk(0, 0, 7'h0, 1, 8'h2E, 1, 0, 0, 0, 5, 1, 1));
      tbl.push_back(mk(0, 0, 7'h0, 1, 8'h17, 1, 0, 0, 0, 6, 1, 1));
      // burst loss: 00 in place of AE, 57, 8E (HD 5, 5, 4)
      tbl.push_back(mk(0, 0, 7'h0, 1, 8'h00, 1, 1, 0, 5, 7, 2, 6));
      tbl.push_back(mk(0, 0, 7'h0, 1, 8'h00, 1, 1, 0, 5, 8, 3, 11));
      tbl.push_back(mk(0, 0, 7'h0, 1, 8'h00, 0, 1, 1, 4, 9, 4, 15));
      // relock: predictor was reseeded from 00, so 47 misses, then 4 matches
      tbl.push_back(mk(0, 0, 7'h0, 1, 8'h47, 0, 0, 0, 4, 9, 4, 15));
      tbl.push_back(mk(0, 0, 7'h0, 1, 8'h86, 0, 0, 0, 0, 9, 4, 15));
      tbl.push_back(mk(0, 0, 7'h0, 1, 8'h43, 0, 0, 0, 0, 9, 4, 15));
      tbl.push_back(mk(0, 0, 7'h0, 1, 8'h84, 0, 0, 0, 0, 9, 4, 15));
      tbl.push_back(mk(0, 0, 7'h0, 1, 8'h42, 1, 0, 0, 0, 9, 4, 15));
      // acquire noise: EC in place of 93 restarts the run, lock 3 words late
      tbl.push_back(mk(1, 0, 7'h0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 7'h0, 1, 8'hFF, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 7'h0, 1, 8'hDA, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 7'h0, 1, 8'h6D, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 7'h0, 1, 8'hEC, 0, 0, 0, 7, 0, 0, 0));
      tbl.push_back(mk(0, 0, 7'h0, 1, 8'h76, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 7'h0, 1, 8'h3B, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 7'h0, 1, 8'hB8, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 7'h0, 1, 8'h5C, 1, 0, 0, 0, 0, 0, 0));

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_outs("reset", 0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].st, tbl[i].cv, tbl[i].tap, tbl[i].iv, tbl[i].pat);
         check_outs($sformatf("row%0d", i), tbl[i].e_lock, tbl[i].e_err, tbl[i].e_loss,
                    tbl[i].e_hd, tbl[i].e_word, tbl[i].e_errc, tbl[i].e_bit);
      end

      // Saturation: 20 misses as (miss, miss, match) x 10 keeps lock held.
      pw = 8'h5C;
      pw = tb_step(pw, TAP); send(~pw);
      check_outs("sat_miss1", 1, 1, 0, 8, 1, 1, 8);
      pw = tb_step(pw, TAP); send(~pw);
      check_outs("sat_miss2", 1, 1, 0, 8, 2, 2, 15);
      pw = tb_step(pw, TAP); send(pw);
      check("sat_match1.err_flag", 32'(bus.err_flag), 32'd0);
      for (int it = 1; it < 10; it++) begin
         pw = tb_step(pw, TAP); send(~pw);
         pw = tb_step(pw, TAP); send(~pw);
         pw = tb_step(pw, TAP); send(pw);
         check($sformatf("sat_it%0d.locked", it), 32'(bus.locked), 32'd1);
      end
      check_outs("sat_end", 1, 0, 0, 0, 15, 15, 15);
      pw = tb_step(pw, TAP); send(~pw);
      check_outs("sat_extra", 1, 1, 0, 8, 15, 15, 15);

      // start mid-stream with in_valid high: word discarded, back to SEED.
      drive(1'b1, 1'b0, 7'h00, 1'b1, 8'hFF);
      check_outs("restart", 0, 0, 0, 0, 0, 0, 0);
      send(8'hDA); check("rs_seed.locked", 32'(bus.locked), 32'd0);
      send(8'h6D); check("rs_w2.locked",   32'(bus.locked), 32'd0);
      send(8'h93); check("rs_w3.locked",   32'(bus.locked), 32'd0);
      send(8'hEC); check("rs_w4.locked",   32'(bus.locked), 32'd0);
      send(8'h76); check("rs_w5.locked",   32'(bus.locked), 32'd1);

      // cfg_valid while LOCKED must not alter the tap (B8 would miss with tap 0).
      drive(1'b0, 1'b1, 7'h00, 1'b0, 8'h00);
      check("cfg_locked.locked", 32'(bus.locked), 32'd1);
      send(8'h3B);
      check_outs("cfg_w1", 1, 0, 0, 0, 1, 0, 0);
      send(8'hB8);
      check_outs("cfg_w2", 1, 0, 0, 0, 2, 0, 0);

      // Asynchronous reset away from any clock edge.
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_outs("async_rst", 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // IDLE ignores in_valid.
      send(8'hFF);
      check_outs("idle_ignore", 0, 0, 0, 0, 0, 0, 0);

      // Tap resets to 0: plain rotation 08 04 02 01 80 locks (tap 0100101 would not).
      drive(1'b1, 1'b0, 7'h00, 1'b0, 8'h00);
      send(8'h08); send(8'h04); send(8'h02); send(8'h01);
      check("tap0_w4.locked", 32'(bus.locked), 32'd0);
      send(8'h80);
      check("tap0_w5.locked", 32'(bus.locked), 32'd1);

      // All-zero stream locks.
      drive(1'b1, 1'b0, 7'h00, 1'b0, 8'h00);
      check("zero_start.locked", 32'(bus.locked), 32'd0);
      repeat (4) send(8'h00);
      check("zero_w4.locked", 32'(bus.locked), 32'd0);
      send(8'h00);
      check("zero_w5.locked", 32'(bus.locked), 32'd1);
      send(8'h00);
      check_outs("zero_w6", 1, 0, 0, 0, 1, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
